bus_interconnect: RTL and testbench
===================================

Name: bus_interconnect

Overview:
- Parametrised host-to-device bus between N cores/masters and M memory-mapped slaves (dpram, peripherals). Generalises the single core-to-dpram point wiring.
- Adds round-robin arbitration across hosts, base/mask address decode across devices, and a req/gnt/rvalid handshake. Decode errors are reported back to the host.
- One transaction is outstanding at a time. Sits in the top level between the core_top instances and the device instances.

Parameters:
- NrHosts, 2, number of host ports (1..8).
- NrDevices, 2, number of device ports (1..8).
- DataWidth, 32, data bus width (`DATA_WIDTH).
- AddressWidth, 32, address width (`ADDR_WIDTH).
- HostIdxW, 1, host index width = max(1, clog2(NrHosts)).
- DevIdxW, 1, device index width = max(1, clog2(NrDevices)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- host_req_i  in  NrHosts  per-host request; held until gnt.
- host_we_i  in  NrHosts  1 = write.
- host_be_i  in  NrHosts*DataWidth/8  byte enables, host h at slice h.
- host_addr_i  in  NrHosts*AddressWidth  address.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_gnt_o  out  NrHosts  request accepted (one-hot or zero).
- host_rvalid_o  out  NrHosts  response valid (one-hot or zero).
- host_rdata_o  out  NrHosts*DataWidth  response data (all slices carry same value).
- host_err_o  out  NrHosts  decode error, qualified by rvalid.
- cfg_device_addr_base_i  in  NrDevices*AddressWidth  device base address.
- cfg_device_addr_mask_i  in  NrDevices*AddressWidth  device address mask.
- device_req_o  out  NrDevices  device request (one-hot or zero).
- device_we_o  out  1  forwarded write enable.
- device_be_o  out  DataWidth/8  forwarded byte enables.
- device_addr_o  out  AddressWidth  forwarded address, unmodified.
- device_wdata_o  out  DataWidth  forwarded write data.
- device_gnt_i  in  NrDevices  device accepted request.
- device_rvalid_i  in  NrDevices  device response valid.
- device_rdata_i  in  NrDevices*DataWidth  device read data.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, rr_ptr=NrHosts-1 (host 0 wins first), latched indices 0.
  - All gnt/rvalid/req/err outputs 0; rdata 0.
- Decode: device d matches when (addr & mask[d]) == base[d]. The lowest matching index wins. No match = decode error.
- Arbitration: round-robin over host_req_i, searching from rr_ptr+1 with wrap-around. rr_ptr is loaded with the winning host index only at host grant.
- FSM states: IDLE, ADDR, DATA, ERR.
  - IDLE, no req: all outputs idle.
  - IDLE, winner h decodes to device d: device_req_o[d]=1 combinationally, with h's we/be/addr/wdata muxed onto the device bus.
    - device_gnt_i[d]=1 same cycle: host_gnt_o[h]=1, latch h,d, go DATA (zero-wait grant).
    - Otherwise: latch h,d, go ADDR.
  - IDLE, winner h has a decode error: host_gnt_o[h]=1, latch h, go ERR.
  - ADDR: selection is locked. Requests from other hosts are ignored, even higher-priority ones. Keep driving device_req_o[d] from latched h. On device_gnt_i[d]: host_gnt_o[h]=1, go DATA.
  - DATA: device_req_o=0, no grants. On device_rvalid_i[d]: host_rvalid_o[h]=1, host_rdata=device_rdata[d], err=0, go IDLE. Wait is unbounded; there is no timeout.
  - ERR: exactly one cycle. host_rvalid_o[h]=1, err[h]=1, rdata=0, go IDLE.
- Latency: minimum 2 cycles from request to next grant (grant cycle, then response cycle). IDLE re-arbitrates on the cycle after rvalid.
- rvalid and gnt on an unselected device are ignored. Writes produce an rvalid like reads; rdata is passed through unchanged.
- Hosts that drop req before gnt in ADDR violate protocol; behaviour is unspecified.
- Reset mid-transaction aborts immediately. Devices must tolerate a lost response.

Test Plan (NrHosts=2, NrDevices=2; base0=0x00000000, mask0=0xFFF00000; base1=0x10000000, mask1=0xFFFFF000):
1. Host0 read 0x00000040, device0 gnt same cycle, rvalid next cycle with 0xDEADBEEF -> host_gnt_o=01 cycle 0, host_rvalid_o=01 and rdata=0xDEADBEEF cycle 1, err=0.
2. Host0 and host1 both request 0x00000100 continuously, zero-wait device -> grants alternate 0,1,0,1 starting with host0 after reset.
3. Host1 write 0x10000004 data 0x12345678 be=0xF, device1 gnt delayed 3 cycles -> device_req_o=10 held 4 cycles with stable addr/wdata/be; host0 request raised mid-wait is not granted until after host1's rvalid.
4. Host0 read 0x20000000 (no match) -> gnt cycle 0; rvalid=1, err=1, rdata=0 cycle 1; no device_req_o asserted.
5. Overlapping decode: base1=0x00000000, mask1=0xFFF00000 -> address 0x00000010 goes to device0 only.
6. rst_i pulled low while in DATA -> all outputs 0 asynchronously; after release, a host1-only request is granted and rr_ptr restarts with host0 priority.

Source files
------------

// File: rtl/bus_interconnect.sv
// Host-to-device bus: round-robin arbitration over N hosts, base/mask decode over M devices,
// one outstanding req/gnt/rvalid transaction at a time, with decode errors returned to the host.
module bus_interconnect #(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 2,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int HostIdxW     = (NrHosts > 1) ? $clog2(NrHosts) : 1,
   parameter int DevIdxW      = (NrDevices > 1) ? $clog2(NrDevices) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NrHosts-1:0]                host_req_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i,
   output logic [NrDevices-1:0]              device_req_o,
   output logic                              device_we_o,
   output logic [DataWidth/8-1:0]            device_be_o,
   output logic [AddressWidth-1:0]           device_addr_o,
   output logic [DataWidth-1:0]              device_wdata_o,
   input  logic [NrDevices-1:0]              device_gnt_i,
   input  logic [NrDevices-1:0]              device_rvalid_i,
   input  logic [NrDevices*DataWidth-1:0]    device_rdata_i
);

   localparam int BeW = DataWidth / 8;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StErr
   } state_e;

   state_e                state_q, state_d;
   logic [HostIdxW-1:0]   rrPtr_q, rrPtr_d;
   logic [HostIdxW-1:0]   hostSel_q, hostSel_d;
   logic [DevIdxW-1:0]    devSel_q, devSel_d;

   logic                  arbValid;
   logic [HostIdxW-1:0]   arbHost;
   logic [AddressWidth-1:0] arbAddr;
   logic                  decHit;
   logic [DevIdxW-1:0]    decDev;
   logic                  busActive;
   logic [HostIdxW-1:0]   busHost;
   logic [DataWidth-1:0]  rspData;

   // Walk downward so the requester closest after rrPtr_q is the last one assigned.
   always_comb begin
      int idx;
      idx      = 0;
      arbValid = 1'b0;
      arbHost  = '0;
      for (int i = NrHosts; i >= 1; i--) begin
         idx = (int'(rrPtr_q) + i) % NrHosts;
         if (host_req_i[HostIdxW'(idx)]) begin
            arbValid = 1'b1;
            arbHost  = HostIdxW'(idx);
         end
      end
   end

   // Same downward trick: the lowest matching device index wins overlapping windows.
   always_comb begin
      arbAddr = host_addr_i[int'(arbHost)*AddressWidth +: AddressWidth];
      decHit  = 1'b0;
      decDev  = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((arbAddr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
             cfg_device_addr_base_i[d*AddressWidth +: AddressWidth]) begin
            decHit = 1'b1;
            decDev = DevIdxW'(d);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rrPtr_d       = rrPtr_q;
      hostSel_d     = hostSel_q;
      devSel_d      = devSel_q;
      busActive     = 1'b0;
      busHost       = hostSel_q;
      rspData       = '0;
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      device_req_o  = '0;

      case (state_q)
         StIdle: begin
            if (arbValid) begin
               hostSel_d = arbHost;
               busHost   = arbHost;
               if (decHit) begin
                  device_req_o[decDev] = 1'b1;
                  busActive            = 1'b1;
                  devSel_d             = decDev;
                  if (device_gnt_i[decDev]) begin
                     host_gnt_o[arbHost] = 1'b1;
                     rrPtr_d             = arbHost;
                     state_d             = StData;
                  end else begin
                     state_d = StAddr;
                  end
               end else begin
                  host_gnt_o[arbHost] = 1'b1;
                  rrPtr_d             = arbHost;
                  state_d             = StErr;
               end
            end
         end
         StAddr: begin
            device_req_o[devSel_q] = 1'b1;
            busActive              = 1'b1;
            if (device_gnt_i[devSel_q]) begin
               host_gnt_o[hostSel_q] = 1'b1;
               rrPtr_d               = hostSel_q;
               state_d               = StData;
            end
         end
         StData: begin
            if (device_rvalid_i[devSel_q]) begin
               host_rvalid_o[hostSel_q] = 1'b1;
               rspData = device_rdata_i[int'(devSel_q)*DataWidth +: DataWidth];
               state_d = StIdle;
            end
         end
         StErr: begin
            host_rvalid_o[hostSel_q] = 1'b1;
            host_err_o[hostSel_q]    = 1'b1;
            state_d                  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      device_we_o    = 1'b0;
      device_be_o    = '0;
      device_addr_o  = '0;
      device_wdata_o = '0;
      if (busActive) begin
         device_we_o    = host_we_i[busHost];
         device_be_o    = host_be_i[int'(busHost)*BeW +: BeW];
         device_addr_o  = host_addr_i[int'(busHost)*AddressWidth +: AddressWidth];
         device_wdata_o = host_wdata_i[int'(busHost)*DataWidth +: DataWidth];
      end
      host_rdata_o = {NrHosts{rspData}};

      // Outputs must drop the moment reset asserts, not at the next edge.
      if (!rst_i) begin
         host_gnt_o     = '0;
         host_rvalid_o  = '0;
         host_err_o     = '0;
         host_rdata_o   = '0;
         device_req_o   = '0;
         device_we_o    = 1'b0;
         device_be_o    = '0;
         device_addr_o  = '0;
         device_wdata_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         rrPtr_q   <= HostIdxW'(NrHosts - 1);
         hostSel_q <= '0;
         devSel_q  <= '0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         hostSel_q <= hostSel_d;
         devSel_q  <= devSel_d;
      end
   end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed vector table, hand-written reset and
// overlap sequences, then random traffic against a transaction-level reference model.
module tb_bus_interconnect;

   logic        clk;
   logic        rstN;
   logic [1:0]  hostReq, hostWe, hostGnt, hostRvalid, hostErr;
   logic [7:0]  hostBe;
   logic [63:0] hostAddr, hostWdata, hostRdata;
   logic [63:0] cfgBase, cfgMask;
   logic [1:0]  devReq, devGnt, devRvalid;
   logic        devWe;
   logic [3:0]  devBe;
   logic [31:0] devAddr, devWdata;
   logic [63:0] devRdata;

   int checks   = 0;
   int failures = 0;

   logic        hReqA[2];
   logic        hWeA[2];
   logic [3:0]  hBeA[2];
   logic [31:0] hA[2];
   logic [31:0] hWd[2];
   logic [1:0]  dG, dRv;
   logic [31:0] dRd[2];
   logic [31:0] cBase[2];
   logic [31:0] cMask[2];

   logic [1:0]  eGnt, eRv, eErr, eDevReq;
   logic [31:0] eRdata, eAddr, eWdata;
   logic        eWe;
   logic [3:0]  eBe;

   int phase, curH, curD, lastH;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [1:0]  dGnt;
      logic [1:0]  dRvl;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  xGnt;
      logic [1:0]  xRv;
      logic [1:0]  xErr;
      logic [31:0] xRdata;
      logic [1:0]  xDevReq;
      logic        xWe;
      logic [3:0]  xBe;
      logic [31:0] xAddr;
      logic [31:0] xWdata;
   } vec_t;

   vec_t vecs[19];

   bus_interconnect dut (
      .clk_i                  (clk),
      .rst_i                  (rstN),
      .host_req_i             (hostReq),
      .host_we_i              (hostWe),
      .host_be_i              (hostBe),
      .host_addr_i            (hostAddr),
      .host_wdata_i           (hostWdata),
      .host_gnt_o             (hostGnt),
      .host_rvalid_o          (hostRvalid),
      .host_rdata_o           (hostRdata),
      .host_err_o             (hostErr),
      .cfg_device_addr_base_i (cfgBase),
      .cfg_device_addr_mask_i (cfgMask),
      .device_req_o           (devReq),
      .device_we_o            (devWe),
      .device_be_o            (devBe),
      .device_addr_o          (devAddr),
      .device_wdata_o         (devWdata),
      .device_gnt_i           (devGnt),
      .device_rvalid_i        (devRvalid),
      .device_rdata_i         (devRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus();
      hostReq   = {hReqA[1], hReqA[0]};
      hostWe    = {hWeA[1], hWeA[0]};
      hostBe    = {hBeA[1], hBeA[0]};
      hostAddr  = {hA[1], hA[0]};
      hostWdata = {hWd[1], hWd[0]};
      devGnt    = dG;
      devRvalid = dRv;
      devRdata  = {dRd[1], dRd[0]};
      cfgBase   = {cBase[1], cBase[0]};
      cfgMask   = {cMask[1], cMask[0]};
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkCycle(input string tag);
      checkOutput({tag, " gnt"}, 64'(hostGnt), 64'(eGnt));
      checkOutput({tag, " rvalid"}, 64'(hostRvalid), 64'(eRv));
      checkOutput({tag, " dev_req"}, 64'(devReq), 64'(eDevReq));
      if (eRv != 2'b00) begin
         checkOutput({tag, " err"}, 64'(hostErr), 64'(eErr));
         checkOutput({tag, " rdata"}, hostRdata, {eRdata, eRdata});
      end
      if (eDevReq != 2'b00) begin
         checkOutput({tag, " dev_we"}, 64'(devWe), 64'(eWe));
         checkOutput({tag, " dev_be"}, 64'(devBe), 64'(eBe));
         checkOutput({tag, " dev_addr"}, 64'(devAddr), 64'(eAddr));
         checkOutput({tag, " dev_wdata"}, 64'(devWdata), 64'(eWdata));
      end
   endtask

   task automatic clearInputs();
      for (int h = 0; h < 2; h++) begin
         hReqA[h] = 1'b0;
         hWeA[h]  = 1'b0;
         hA[h]    = '0;
      end
      dG     = '0;
      dRv    = '0;
      dRd[0] = '0;
      dRd[1] = '0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rstN = 1'b0;
      clearInputs();
      applyStimulus();
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   function automatic int decodeAddr(input logic [31:0] addr);
      for (int d = 0; d < 2; d++)
         if ((addr & cMask[d]) == cBase[d]) return d;
      return -1;
   endfunction

   task automatic expectBusFrom(input int h);
      eWe    = hWeA[h];
      eBe    = hBeA[h];
      eAddr  = hA[h];
      eWdata = hWd[h];
   endtask

   // Transaction-level model: who is served next, which device, and which response is due.
   task automatic modelStep();
      int win, d;
      eGnt = '0; eRv = '0; eErr = '0; eDevReq = '0; eRdata = '0;
      eWe = 1'b0; eBe = '0; eAddr = '0; eWdata = '0;
      win = -1;
      case (phase)
         0: begin
            for (int k = 1; k <= 2; k++)
               if (win < 0 && hReqA[(lastH + k) % 2]) win = (lastH + k) % 2;
            if (win >= 0) begin
               curH = win;
               d = decodeAddr(hA[win]);
               if (d >= 0) begin
                  curD = d;
                  eDevReq[d] = 1'b1;
                  expectBusFrom(win);
                  if (dG[d]) begin
                     eGnt[win] = 1'b1; lastH = win; phase = 2;
                  end else begin
                     phase = 1;
                  end
               end else begin
                  eGnt[win] = 1'b1; lastH = win; phase = 3;
               end
            end
         end
         1: begin
            eDevReq[curD] = 1'b1;
            expectBusFrom(curH);
            if (dG[curD]) begin
               eGnt[curH] = 1'b1; lastH = curH; phase = 2;
            end
         end
         2: begin
            if (dRv[curD]) begin
               eRv[curH] = 1'b1; eRdata = dRd[curD]; phase = 0;
            end
         end
         default: begin
            eRv[curH] = 1'b1; eErr[curH] = 1'b1; phase = 0;
         end
      endcase
   endtask

   initial begin
      logic [1:0] prevGnt;
      int r;

      cBase[0] = 32'h0000_0000; cMask[0] = 32'hFFF0_0000;
      cBase[1] = 32'h1000_0000; cMask[1] = 32'hFFFF_F000;
      hWd[0] = 32'hCAFE_0000; hWd[1] = 32'h1234_5678;
      hBeA[0] = 4'h3; hBeA[1] = 4'hF;
      rstN = 1'b1;
      clearInputs();
      applyStimulus();

      //            rst  req    we     a0            a1            dGnt   dRvl   rd0           rd1           xGnt   xRv    xErr   xRdata        xDevReq xWe  xBe   xAddr         xWdata
      vecs[0]  = '{1'b1, 2'b01, 2'b00, 32'h0000_0040, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 32'h0,        2'b01, 1'b0, 4'h3, 32'h0000_0040, 32'hCAFE_0000};
      vecs[1]  = '{1'b0, 2'b00, 2'b00, 32'h0000_0040, 32'h0,        2'b00, 2'b01, 32'hDEAD_BEEF, 32'h0,        2'b00, 2'b01, 2'b00, 32'hDEAD_BEEF, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[2]  = '{1'b1, 2'b11, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b01, 2'b00, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 32'h0,        2'b01, 1'b0, 4'h3, 32'h0000_0100, 32'hCAFE_0000};
      vecs[3]  = '{1'b0, 2'b11, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b00, 2'b01, 32'h1111_1111, 32'h0,        2'b00, 2'b01, 2'b00, 32'h1111_1111, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[4]  = '{1'b0, 2'b11, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b01, 2'b00, 32'h0,        32'h0,        2'b10, 2'b00, 2'b00, 32'h0,        2'b01, 1'b0, 4'hF, 32'h0000_0104, 32'h1234_5678};
      vecs[5]  = '{1'b0, 2'b11, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b00, 2'b01, 32'h2222_2222, 32'h0,        2'b00, 2'b10, 2'b00, 32'h2222_2222, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[6]  = '{1'b0, 2'b11, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b01, 2'b00, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 32'h0,        2'b01, 1'b0, 4'h3, 32'h0000_0100, 32'hCAFE_0000};
      vecs[7]  = '{1'b0, 2'b00, 2'b00, 32'h0000_0100, 32'h0000_0104, 2'b00, 2'b01, 32'h3333_3333, 32'h0,        2'b00, 2'b01, 2'b00, 32'h3333_3333, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[8]  = '{1'b0, 2'b10, 2'b10, 32'h0000_0040, 32'h1000_0004, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        2'b10, 1'b1, 4'hF, 32'h1000_0004, 32'h1234_5678};
      vecs[9]  = '{1'b0, 2'b11, 2'b10, 32'h0000_0040, 32'h1000_0004, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        2'b10, 1'b1, 4'hF, 32'h1000_0004, 32'h1234_5678};
      vecs[10] = '{1'b0, 2'b11, 2'b10, 32'h0000_0040, 32'h1000_0004, 2'b01, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        2'b10, 1'b1, 4'hF, 32'h1000_0004, 32'h1234_5678};
      vecs[11] = '{1'b0, 2'b11, 2'b10, 32'h0000_0040, 32'h1000_0004, 2'b10, 2'b00, 32'h0,        32'h0,        2'b10, 2'b00, 2'b00, 32'h0,        2'b10, 1'b1, 4'hF, 32'h1000_0004, 32'h1234_5678};
      vecs[12] = '{1'b0, 2'b01, 2'b00, 32'h0000_0040, 32'h1000_0004, 2'b00, 2'b01, 32'h5555_5555, 32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[13] = '{1'b0, 2'b01, 2'b00, 32'h0000_0040, 32'h1000_0004, 2'b00, 2'b10, 32'h0,        32'hAAAA_5555, 2'b00, 2'b10, 2'b00, 32'hAAAA_5555, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[14] = '{1'b0, 2'b01, 2'b00, 32'h0000_0040, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 32'h0,        2'b01, 1'b0, 4'h3, 32'h0000_0040, 32'hCAFE_0000};
      vecs[15] = '{1'b0, 2'b00, 2'b00, 32'h0000_0040, 32'h0,        2'b00, 2'b01, 32'h0102_0304, 32'h0,        2'b00, 2'b01, 2'b00, 32'h0102_0304, 2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[16] = '{1'b0, 2'b01, 2'b00, 32'h2000_0000, 32'h0,        2'b11, 2'b00, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[17] = '{1'b0, 2'b00, 2'b00, 32'h2000_0000, 32'h0,        2'b00, 2'b11, 32'h7777_7777, 32'h8888_8888, 2'b00, 2'b01, 2'b01, 32'h0,        2'b00, 1'b0, 4'h0, 32'h0,         32'h0};
      vecs[18] = '{1'b0, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 1'b0, 4'h0, 32'h0,         32'h0};

      rstN = 1'b0;
      #1;
      checkOutput("reset gnt", 64'(hostGnt), 64'd0);
      checkOutput("reset rvalid", 64'(hostRvalid), 64'd0);
      checkOutput("reset err", 64'(hostErr), 64'd0);
      checkOutput("reset rdata", hostRdata, 64'd0);
      checkOutput("reset dev_req", 64'(devReq), 64'd0);

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].rst) resetDut();
         @(negedge clk);
         hReqA[0] = vecs[i].req[0]; hReqA[1] = vecs[i].req[1];
         hWeA[0]  = vecs[i].we[0];  hWeA[1]  = vecs[i].we[1];
         hA[0]    = vecs[i].a0;     hA[1]    = vecs[i].a1;
         dG = vecs[i].dGnt; dRv = vecs[i].dRvl;
         dRd[0] = vecs[i].rd0; dRd[1] = vecs[i].rd1;
         applyStimulus();
         #1;
         eGnt = vecs[i].xGnt; eRv = vecs[i].xRv; eErr = vecs[i].xErr;
         eRdata = vecs[i].xRdata; eDevReq = vecs[i].xDevReq;
         eWe = vecs[i].xWe; eBe = vecs[i].xBe; eAddr = vecs[i].xAddr; eWdata = vecs[i].xWdata;
         checkCycle($sformatf("vec%0d", i));
      end

      // Overlapping windows: device0 must win over device1.
      @(negedge clk);
      cBase[1] = 32'h0; cMask[1] = 32'hFFF0_0000;
      clearInputs();
      hReqA[0] = 1'b1; hA[0] = 32'h0000_0010; dG = 2'b11;
      applyStimulus();
      #1;
      checkOutput("overlap dev_req", 64'(devReq), 64'h1);
      checkOutput("overlap gnt", 64'(hostGnt), 64'h1);
      @(negedge clk);
      clearInputs();
      dRv = 2'b11; dRd[0] = 32'h5A5A_0000; dRd[1] = 32'hA5A5_FFFF;
      applyStimulus();
      #1;
      checkOutput("overlap rvalid", 64'(hostRvalid), 64'h1);
      checkOutput("overlap rdata", hostRdata, {32'h5A5A_0000, 32'h5A5A_0000});
      cBase[1] = 32'h1000_0000; cMask[1] = 32'hFFFF_F000;

      // Reset while a response is pending; host1 was last served so host0 priority proves the restart.
      @(negedge clk);
      clearInputs();
      hReqA[1] = 1'b1; hA[1] = 32'h0000_0104; dG = 2'b01;
      applyStimulus();
      #1;
      checkOutput("pre-reset gnt", 64'(hostGnt), 64'h2);
      @(negedge clk);
      clearInputs();
      hReqA[0] = 1'b1; hReqA[1] = 1'b1; hA[0] = 32'h40; hA[1] = 32'h104;
      dG = 2'b01; dRv = 2'b01; dRd[0] = 32'h9999_9999;
      applyStimulus();
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("async reset gnt", 64'(hostGnt), 64'd0);
      checkOutput("async reset rvalid", 64'(hostRvalid), 64'd0);
      checkOutput("async reset err", 64'(hostErr), 64'd0);
      checkOutput("async reset rdata", hostRdata, 64'd0);
      checkOutput("async reset dev_req", 64'(devReq), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      dRv = 2'b00;
      applyStimulus();
      #1;
      checkOutput("restart priority gnt", 64'(hostGnt), 64'h1);
      @(negedge clk);
      hReqA[0] = 1'b0; dG = 2'b00; dRv = 2'b01; dRd[0] = 32'h4444_0000;
      applyStimulus();
      #1;
      checkOutput("restart rvalid", 64'(hostRvalid), 64'h1);
      @(negedge clk);
      dG = 2'b01; dRv = 2'b00;
      applyStimulus();
      #1;
      checkOutput("host1-only gnt", 64'(hostGnt), 64'h2);
      checkOutput("host1-only dev_addr", 64'(devAddr), 64'h104);

      // Random traffic against the model; stray gnt/rvalid on idle devices is deliberate.
      resetDut();
      phase = 0; curH = 0; curD = 0; lastH = 1;
      prevGnt = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int h = 0; h < 2; h++) begin
            if (prevGnt[h]) hReqA[h] = 1'b0;
            if (!hReqA[h] && $urandom_range(0, 2) == 0) begin
               hReqA[h] = 1'b1;
               hWeA[h]  = 1'($urandom_range(0, 1));
               hBeA[h]  = 4'($urandom);
               hWd[h]   = $urandom;
               r = $urandom_range(0, 9);
               if (r < 4)      hA[h] = {12'h000, 20'($urandom)};
               else if (r < 8) hA[h] = 32'h1000_0000 | {20'h0, 12'($urandom)};
               else            hA[h] = 32'h2000_0000 | {4'h0, 28'($urandom)};
            end
         end
         dG = 2'($urandom); dRv = 2'($urandom);
         dRd[0] = $urandom; dRd[1] = $urandom;
         applyStimulus();
         #1;
         modelStep();
         checkCycle($sformatf("rand%0d", cyc));
         prevGnt = eGnt;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
